// File: rtl/rect_loop_sampler.sv
// rect_loop_sampler
//   Rectangle-loop (checkerboard swap) sampler for a binary ROWS x COLS matrix.
//   A run loads a matrix and then repeatedly draws two rows and two columns
//   from a Galois LFSR. Whenever the four selected corners form a
//   checkerboard, all four bits are inverted. This keeps every row sum and
//   every column sum unchanged. The run ends after the requested number of
//   swaps, or when the attempt limit is reached.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      begin a run (sampled in IDLE only)
//   i_num_iter   required successful swaps (captured on start)
//   i_m_in       input matrix, row-major, bit r*COLS+c (captured on start)
//   i_seed_load  load the LFSR from i_seed (IDLE only)
//   i_seed       LFSR seed; zero is replaced by one
//   o_m_out      working matrix; final once o_done pulses, then held
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse at run end
//   o_timeout    run ended on the attempt limit
//   o_swaps      successful swaps in the current/last run
//   o_attempts   draws evaluated in the current/last run
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; seed load allowed
// PICK  | advance LFSR; the new LFSR value holds the r1/c1/r2/c2 draw
// CHECK | count the attempt, test validity and checkerboard pattern
// SWAP  | invert the four corners, count the swap
// FIN   | one-cycle done pulse, then back to IDLE

module rect_loop_sampler #(
  parameter int                ROWS      = 8,
  parameter int                COLS      = 8,
  parameter int                ITER_W    = 12,
  parameter int                ATT_W     = 20,
  parameter int                MAX_ATT   = 2**20-1,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ITER_W-1:0]    i_num_iter,
  input  logic [ROWS*COLS-1:0] i_m_in,
  input  logic                 i_seed_load,
  input  logic [LFSR_W-1:0]    i_seed,
  output logic [ROWS*COLS-1:0] o_m_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [ITER_W-1:0]    o_swaps,
  output logic [ATT_W-1:0]     o_attempts
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // One extra bit so the range compares below also work for power-of-two sizes.
  localparam logic [RW:0]       ROWS_L    = ROWS[RW:0];
  localparam logic [CW:0]       COLS_L    = COLS[CW:0];
  localparam logic [ATT_W-1:0]  MAX_ATT_L = MAX_ATT[ATT_W-1:0];
  localparam logic [LFSR_W-1:0] LFSR_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_CHECK,
    S_SWAP,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ROWS-1:0][COLS-1:0] r_m;
  logic [LFSR_W-1:0]         r_lfsr;
  logic [ITER_W-1:0]         r_num_iter;
  logic [ITER_W-1:0]         r_swaps;
  logic [ATT_W-1:0]          r_attempts;
  logic                      r_timeout;

  logic [LFSR_W-1:0] w_lfsr_step;
  logic [RW-1:0]     w_r1;
  logic [RW-1:0]     w_r2;
  logic [CW-1:0]     w_c1;
  logic [CW-1:0]     w_c2;
  logic              w_m11;
  logic              w_m12;
  logic              w_m21;
  logic              w_m22;
  logic              w_valid;
  logic              w_cb;
  logic              w_hit;
  logic [ATT_W-1:0]  w_att_inc;
  logic [ITER_W-1:0] w_swp_inc;
  logic              w_att_lim_chk;
  logic              w_att_lim_swp;
  logic              w_swp_done;
  logic              w_set_to;

  // Galois step: shift right, fold the taps back in when a one falls out.
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

  // The LFSR does not move between PICK and SWAP, so the draw is read
  // straight from it instead of being copied into separate registers.
  assign w_r1 = r_lfsr[RW-1:0];
  assign w_c1 = r_lfsr[RW+CW-1:RW];
  assign w_r2 = r_lfsr[2*RW+CW-1:RW+CW];
  assign w_c2 = r_lfsr[2*RW+2*CW-1:2*RW+CW];

  assign w_m11 = r_m[w_r1][w_c1];
  assign w_m12 = r_m[w_r1][w_c2];
  assign w_m21 = r_m[w_r2][w_c1];
  assign w_m22 = r_m[w_r2][w_c2];

  // Corner reads above may be out of range for non power-of-two sizes;
  // w_valid masks those draws before the pattern test matters.
  assign w_valid = ({1'b0, w_r1} < ROWS_L) && ({1'b0, w_r2} < ROWS_L) &&
                   ({1'b0, w_c1} < COLS_L) && ({1'b0, w_c2} < COLS_L) &&
                   (w_r1 != w_r2) && (w_c1 != w_c2);
  assign w_cb    = (w_m11 == w_m22) && (w_m12 == w_m21) && (w_m11 != w_m12);
  assign w_hit   = w_valid && w_cb;

  assign w_att_inc     = r_attempts + 1'b1;
  assign w_swp_inc     = r_swaps + 1'b1;
  assign w_att_lim_chk = (w_att_inc == MAX_ATT_L);
  assign w_att_lim_swp = (r_attempts == MAX_ATT_L);
  assign w_swp_done    = (w_swp_inc == r_num_iter);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_set_to    = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_FIN);
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_num_iter == '0) ? S_FIN : S_PICK;
        end
      end
      S_PICK: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_hit) begin
          w_state_nxt = S_SWAP;
        end else if (w_att_lim_chk) begin
          w_state_nxt = S_FIN;
          w_set_to    = 1'b1;
        end else begin
          w_state_nxt = S_PICK;
        end
      end
      S_SWAP: begin
        if (w_swp_done) begin
          w_state_nxt = S_FIN;
        end else if (w_att_lim_swp) begin
          w_state_nxt = S_FIN;
          w_set_to    = 1'b1;
        end else begin
          w_state_nxt = S_PICK;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m        <= '0;
      r_lfsr     <= LFSR_ONE;
      r_num_iter <= '0;
      r_swaps    <= '0;
      r_attempts <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Seed load and start in the same cycle: the run's first PICK
          // steps from the freshly loaded seed.
          if (i_seed_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_ONE : i_seed;
          end
          if (i_start) begin
            r_m        <= i_m_in;
            r_num_iter <= i_num_iter;
            r_swaps    <= '0;
            r_attempts <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_PICK: begin
          r_lfsr <= w_lfsr_step;
        end
        S_CHECK: begin
          r_attempts <= w_att_inc;
          if (w_set_to) begin
            r_timeout <= 1'b1;
          end
        end
        S_SWAP: begin
          r_m[w_r1][w_c1] <= ~w_m11;
          r_m[w_r1][w_c2] <= ~w_m12;
          r_m[w_r2][w_c1] <= ~w_m21;
          r_m[w_r2][w_c2] <= ~w_m22;
          r_swaps         <= w_swp_inc;
          if (w_set_to) begin
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_m_out    = r_m;
  assign o_swaps    = r_swaps;
  assign o_attempts = r_attempts;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_rect_loop_sampler.sv
// Testbench for rect_loop_sampler.
//   Two instances: a 2x2 with a small attempt limit of 50 and an 8x8 with
//   default parameters. Each run pushes the reference-model result into a
//   per-instance queue. A monitor pops the queue and compares when done
//   pulses.

module tb_rect_loop_sampler;

  typedef struct {
    logic [63:0] m_in;
    logic [63:0] m_out;
    int          swaps;
    int          attempts;
    bit          timeout;
    int          lat;
    int          swap_at;
    int          rows;
    int          cols;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // 2x2 instance
  logic        a_start, a_seed_load, a_busy, a_done, a_timeout;
  logic [11:0] a_num_iter, a_swaps;
  logic [3:0]  a_m_in, a_m_out;
  logic [15:0] a_seed;
  logic [19:0] a_attempts;

  // 8x8 instance
  logic        b_start, b_seed_load, b_busy, b_done, b_timeout;
  logic [11:0] b_num_iter, b_swaps;
  logic [63:0] b_m_in, b_m_out;
  logic [15:0] b_seed;
  logic [19:0] b_attempts;

  rect_loop_sampler #(.ROWS(2), .COLS(2), .MAX_ATT(50)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_num_iter(a_num_iter),
    .i_m_in(a_m_in), .i_seed_load(a_seed_load), .i_seed(a_seed),
    .o_m_out(a_m_out), .o_busy(a_busy), .o_done(a_done), .o_timeout(a_timeout),
    .o_swaps(a_swaps), .o_attempts(a_attempts)
  );

  rect_loop_sampler u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_num_iter(b_num_iter),
    .i_m_in(b_m_in), .i_seed_load(b_seed_load), .i_seed(b_seed),
    .o_m_out(b_m_out), .o_busy(b_busy), .o_done(b_done), .o_timeout(b_timeout),
    .o_swaps(b_swaps), .o_attempts(b_attempts)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic walk of the sampling procedure.
  // lat counts cycles after the start cycle up to and including the done cycle.
  function automatic exp_t model(int rows, int cols, int max_att, logic [15:0] seed,
                                 logic [63:0] m_in, int n);
    exp_t e;
    int   rw, cw, s, r1, c1, r2, c2;
    bit   ok, fin;
    rw = (rows > 1) ? $clog2(rows) : 1;
    cw = (cols > 1) ? $clog2(cols) : 1;
    e.m_in = m_in; e.m_out = m_in; e.swaps = 0; e.attempts = 0; e.timeout = 0;
    e.lat = 1; e.swap_at = -1; e.rows = rows; e.cols = cols; e.start_cyc = 0;
    s = (seed == 16'h0) ? 1 : int'(seed);
    fin = (n == 0);
    while (!fin) begin
      if ((s & 1) == 1) s = (s >> 1) ^ 'hB400;
      else              s = s >> 1;
      e.lat++;
      r1 = s % (1 << rw);
      c1 = (s >> rw) % (1 << cw);
      r2 = (s >> (rw + cw)) % (1 << rw);
      c2 = (s >> (2 * rw + cw)) % (1 << cw);
      e.attempts++;
      e.lat++;
      ok = (r1 < rows) && (r2 < rows) && (c1 < cols) && (c2 < cols) && (r1 != r2) && (c1 != c2);
      if (ok)
        ok = (e.m_out[r1*cols+c1] == e.m_out[r2*cols+c2]) &&
             (e.m_out[r1*cols+c2] == e.m_out[r2*cols+c1]) &&
             (e.m_out[r1*cols+c1] != e.m_out[r1*cols+c2]);
      if (ok) begin
        if (e.swaps == 4) e.swap_at = e.lat;
        e.m_out[r1*cols+c1] = ~e.m_out[r1*cols+c1];
        e.m_out[r1*cols+c2] = ~e.m_out[r1*cols+c2];
        e.m_out[r2*cols+c1] = ~e.m_out[r2*cols+c1];
        e.m_out[r2*cols+c2] = ~e.m_out[r2*cols+c2];
        e.swaps++;
        e.lat++;
        if (e.swaps == n) fin = 1;
        else if (e.attempts == max_att) begin e.timeout = 1; fin = 1; end
      end else if (e.attempts == max_att) begin
        e.timeout = 1;
        fin = 1;
      end
    end
    return e;
  endfunction

  task automatic check_res(string tag, exp_t e, logic [63:0] m, int sw, int att, bit to, int lat);
    chk({tag, "_m_out"}, m, e.m_out);
    chk({tag, "_swaps"}, sw, e.swaps);
    chk({tag, "_attempts"}, att, e.attempts);
    chk({tag, "_timeout"}, {63'b0, to}, {63'b0, e.timeout});
    chk({tag, "_latency"}, lat, e.lat);
    for (int r = 0; r < e.rows; r++) begin
      int pi; int po;
      pi = 0; po = 0;
      for (int c = 0; c < e.cols; c++) begin
        pi += int'(e.m_in[r*e.cols+c]);
        po += int'(m[r*e.cols+c]);
      end
      chk({tag, "_rowsum"}, po, pi);
    end
    for (int c = 0; c < e.cols; c++) begin
      int pi; int po;
      pi = 0; po = 0;
      for (int r = 0; r < e.rows; r++) begin
        pi += int'(e.m_in[r*e.cols+c]);
        po += int'(m[r*e.cols+c]);
      end
      chk({tag, "_colsum"}, po, pi);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];
  int   a_dones = 0, b_dones = 0;
  int   a_last_lat = -1, b_last_lat = -1;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (a_done === 1'b1) begin
      a_dones++;
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_spurious_done: got done with empty queue at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        a_last_lat = cyc - e.start_cyc;
        check_res("a", e, {60'b0, a_m_out}, int'(a_swaps), int'(a_attempts), a_timeout, a_last_lat);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b_done === 1'b1) begin
      b_dones++;
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_spurious_done: got done with empty queue at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        b_last_lat = cyc - e.start_cyc;
        check_res("b", e, b_m_out, int'(b_swaps), int'(b_attempts), b_timeout, b_last_lat);
      end
    end
  end

  task automatic run_a(logic [15:0] seed, logic [3:0] m, int n, logic [15:0] mdl_seed);
    exp_t e;
    int   d0;
    e = model(2, 2, 50, mdl_seed, {60'b0, m}, n);
    @(negedge clk);
    a_seed = seed; a_seed_load = 1'b1;
    @(negedge clk);
    a_seed_load = 1'b0;
    a_m_in = m; a_num_iter = 12'(n); a_start = 1'b1;
    e.start_cyc = cyc;
    d0 = a_dones;
    qa.push_back(e);
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 2000 && a_dones == d0; i++) @(negedge clk);
    if (a_dones == d0) begin
      total++; bad++;
      $display("FAIL a_done_wait: got no done within 2000 cycles expected one");
    end
    repeat (3) @(negedge clk);
    chk("a_one_done", a_dones, d0 + 1);
    chk("a_idle_after", {63'b0, a_busy}, 64'd0);
  endtask

  task automatic run_b(logic [15:0] seed, logic [63:0] m, int n, bit poke, bit coincide, bit abort);
    exp_t e;
    int   d0;
    e = model(8, 8, 2**20-1, seed, m, n);
    @(negedge clk);
    if (!coincide) begin
      b_seed = seed; b_seed_load = 1'b1;
      @(negedge clk);
      b_seed_load = 1'b0;
    end else begin
      b_seed = seed; b_seed_load = 1'b1;
    end
    b_m_in = m; b_num_iter = 12'(n); b_start = 1'b1;
    e.start_cyc = cyc;
    d0 = b_dones;
    if (!abort) qb.push_back(e);
    @(negedge clk);
    b_start = 1'b0; b_seed_load = 1'b0;
    if (abort) begin
      for (int i = 0; i < 60000 && cyc != e.start_cyc + e.swap_at; i++) @(negedge clk);
      chk("b_pre_rst_busy", {63'b0, b_busy}, 64'd1);
      chk("b_pre_rst_swaps", b_swaps, 64'd4);
      rst = 1'b1;
      #1;
      chk("b_rst_m_out", b_m_out, 64'd0);
      chk("b_rst_swaps", b_swaps, 64'd0);
      chk("b_rst_attempts", b_attempts, 64'd0);
      chk("b_rst_busy", {63'b0, b_busy}, 64'd0);
      chk("b_rst_done", {63'b0, b_done}, 64'd0);
      chk("b_rst_timeout", {63'b0, b_timeout}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      b_start = 1'b1; b_seed_load = 1'b1; b_seed = 16'hFFFF;
      b_num_iter = 12'd7; b_m_in = ~m;
      @(negedge clk);
      b_start = 1'b0; b_seed_load = 1'b0;
    end
    for (int i = 0; i < 40000 && b_dones == d0; i++) @(negedge clk);
    if (b_dones == d0) begin
      total++; bad++;
      $display("FAIL b_done_wait: got no done within 40000 cycles expected one");
    end
    repeat (3) @(negedge clk);
    chk("b_one_done", b_dones, d0 + 1);
    chk("b_idle_after", {63'b0, b_busy}, 64'd0);
  endtask

  localparam logic [63:0] M8 = 64'h9F3A_5C21_E6B4_0D78;

  initial begin
    rst = 1'b1;
    a_start = 0; a_seed_load = 0; a_num_iter = 0; a_m_in = 0; a_seed = 0;
    b_start = 0; b_seed_load = 0; b_num_iter = 0; b_m_in = 0; b_seed = 0;
    #2;
    chk("rst_a_m_out", {60'b0, a_m_out}, 64'd0);
    chk("rst_a_swaps", a_swaps, 64'd0);
    chk("rst_a_attempts", a_attempts, 64'd0);
    chk("rst_a_busy", {63'b0, a_busy}, 64'd0);
    chk("rst_a_done", {63'b0, a_done}, 64'd0);
    chk("rst_a_timeout", {63'b0, a_timeout}, 64'd0);
    chk("rst_b_m_out", b_m_out, 64'd0);
    chk("rst_b_busy", {63'b0, b_busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 2x2 checkerboard: two rejected draws, then a swap on the third.
    run_a(16'hACE1, 4'b1001, 1, 16'hACE1);
    chk("t2_m_out", {60'b0, a_m_out}, 64'h6);
    chk("t2_swaps", a_swaps, 64'd1);
    chk("t2_attempts", a_attempts, 64'd3);
    chk("t2_timeout", {63'b0, a_timeout}, 64'd0);
    chk("t2_latency", a_last_lat, 64'd8);

    // All-zero matrix never matches: times out at 50 attempts.
    run_a(16'hACE1, 4'b0000, 5, 16'hACE1);
    chk("t3_timeout", {63'b0, a_timeout}, 64'd1);
    chk("t3_attempts", a_attempts, 64'd50);
    chk("t3_swaps", a_swaps, 64'd0);
    chk("t3_m_out", {60'b0, a_m_out}, 64'd0);
    chk("t3_latency", a_last_lat, 64'd101);

    // Zero iterations: straight to FIN.
    run_a(16'h0042, 4'b1010, 0, 16'h0042);
    chk("t4_m_out", {60'b0, a_m_out}, 64'hA);
    chk("t4_attempts", a_attempts, 64'd0);
    chk("t4_timeout", {63'b0, a_timeout}, 64'd0);
    chk("t4_latency", a_last_lat, 64'd1);

    // Seed zero must behave as seed one.
    run_a(16'h0000, 4'b0110, 2, 16'h0001);

    // 8x8, 100 swaps.
    run_b(16'h1234, M8, 100, 1'b0, 1'b0, 1'b0);
    chk("t6_swaps", b_swaps, 64'd100);
    chk("t6_timeout", {63'b0, b_timeout}, 64'd0);

    // Same run with start/seed_load pulses while busy.
    run_b(16'h1234, M8, 100, 1'b1, 1'b0, 1'b0);
    chk("t7_swaps", b_swaps, 64'd100);

    // Abort in the fifth SWAP, then rerun with seed load coinciding with start.
    run_b(16'h1234, M8, 100, 1'b0, 1'b0, 1'b1);
    run_b(16'h1234, M8, 100, 1'b0, 1'b1, 1'b0);
    chk("t8_swaps", b_swaps, 64'd100);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
